// File: rtl/sr_input_pkg.sv
// Shared types and constants for the set/reset input conditioner.
package sr_input_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } ch_state_e;

  localparam int SYNC_STAGES         = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, stable level and pulse request.
// Release debouncing (RELEASE_WAIT) exists only when SR_RELEASE_DEBOUNCE_EN is defined.
module debounce_channel
  import sr_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic stable_o,
  output logic pulse_req_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  ch_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   pulse_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sync_lvl) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sync_lvl) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
`ifdef SR_RELEASE_DEBOUNCE_EN
        if (!sync_lvl) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
`else
        if (!sync_lvl) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`endif
      end
      RELEASE_WAIT: begin
`ifdef SR_RELEASE_DEBOUNCE_EN
        if (sync_lvl) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        // Unreachable in this build; recover to IDLE.
        state_d = IDLE;
        cnt_d   = '0;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulse request is combinational so the top's register lands on the same edge as stable.
  always_comb begin
    pulse_req = (state_q == PRESS_WAIT) && sync_lvl && (cnt_q == CNT_LAST);
    stable_d  = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  assign stable_o    = stable_q;
  assign pulse_req_o = pulse_req;

endmodule

// File: rtl/sr_input_conditioner.sv
// Set/reset button front end: two debounce channels plus conflict-suppressed pulse registers.
// Optional release debouncing is enabled with SR_RELEASE_DEBOUNCE_EN.
module sr_input_conditioner
  import sr_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  output logic s_pulse,
  output logic r_pulse,
  output logic set_stable,
  output logic reset_stable
);

  logic set_req, reset_req;
  logic s_pulse_q, s_pulse_d;
  logic r_pulse_q, r_pulse_d;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_ch (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      (set_btn),
    .stable_o   (set_stable),
    .pulse_req_o(set_req)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_ch (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      (reset_btn),
    .stable_o   (reset_stable),
    .pulse_req_o(reset_req)
  );

  // Simultaneous requests cancel so the latch never sees S and R together.
  assign s_pulse_d = set_req & ~reset_req;
  assign r_pulse_d = reset_req & ~set_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_pulse_q <= 1'b0;
      r_pulse_q <= 1'b0;
    end else begin
      s_pulse_q <= s_pulse_d;
      r_pulse_q <= r_pulse_d;
    end
  end

  assign s_pulse = s_pulse_q;
  assign r_pulse = r_pulse_q;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Self-checking bench for sr_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_sr_input_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic set_btn;
  logic reset_btn;
  logic s_pulse;
  logic r_pulse;
  logic set_stable;
  logic reset_stable;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  logic [31:0] exp_s_q[$];
  logic [31:0] exp_r_q[$];

  typedef struct {
    logic set_b;
    logic rst_b;
    int   hold;
    int   exp_s;
    int   exp_r;
    logic ss_exp;
    logic rs_exp;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  sr_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_btn     (set_btn),
    .reset_btn   (reset_btn),
    .s_pulse     (s_pulse),
    .r_pulse     (r_pulse),
    .set_stable  (set_stable),
    .reset_stable(reset_stable)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse scoreboard: each observed pulse pops the edge number it was expected on.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("s_r_exclusive", {31'd0, s_pulse & r_pulse}, 32'd0);
      if (s_pulse) begin
        if (exp_s_q.size() == 0) chk("s_pulse_unexpected", cyc, 32'd0);
        else chk("s_pulse_edge", cyc, exp_s_q.pop_front());
      end
      if (r_pulse) begin
        if (exp_r_q.size() == 0) chk("r_pulse_unexpected", cyc, 32'd0);
        else chk("r_pulse_edge", cyc, exp_r_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic start_test(input logic s, input logic r);
    rst_n     = 1'b0;
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    exp_s_q.delete();
    exp_r_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cyc       = 0;
    set_btn   = s;
    reset_btn = r;
  endtask

  task automatic end_test();
    chk("s_pulse_missing", exp_s_q.size(), 32'd0);
    chk("r_pulse_missing", exp_r_q.size(), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 20, 6, 0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 20, 0, 6, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 20, 0, 0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0,  3, 0, 0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0,  4, 6, 0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1,  3, 0, 0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1,  4, 0, 6, 1'b0, 1'b1};

    // Reset state with both buttons pressed.
    rst_n     = 1'b0;
    set_btn   = 1'b1;
    reset_btn = 1'b1;
    mon_en    = 1'b1;
    repeat (4) tick();
    chk("rst_s_pulse", {31'd0, s_pulse}, 32'd0);
    chk("rst_r_pulse", {31'd0, r_pulse}, 32'd0);
    chk("rst_set_stable", {31'd0, set_stable}, 32'd0);
    chk("rst_reset_stable", {31'd0, reset_stable}, 32'd0);

    // Table: buttons high before edge 1, held for 'hold' edges, then released.
    for (int i = 0; i < 7; i++) begin
      start_test(vecs[i].set_b, vecs[i].rst_b);
      if (vecs[i].exp_s != 0) exp_s_q.push_back(vecs[i].exp_s);
      if (vecs[i].exp_r != 0) exp_r_q.push_back(vecs[i].exp_r);
      for (int e = 1; e <= vecs[i].hold + 12; e++) begin
        tick();
        if (e == vecs[i].hold) begin
          set_btn   = 1'b0;
          reset_btn = 1'b0;
        end
        if (e == D + 1) begin
          chk("vec_set_stable_early", {31'd0, set_stable}, 32'd0);
          chk("vec_reset_stable_early", {31'd0, reset_stable}, 32'd0);
        end
        if (e == D + 2) begin
          chk("vec_set_stable", {31'd0, set_stable}, {31'd0, vecs[i].ss_exp});
          chk("vec_reset_stable", {31'd0, reset_stable}, {31'd0, vecs[i].rs_exp});
        end
      end
      chk("vec_set_stable_end", {31'd0, set_stable}, 32'd0);
      chk("vec_reset_stable_end", {31'd0, reset_stable}, 32'd0);
      end_test();
    end

    // Bounce: high 3, low 1, then high from before edge 5.
    start_test(1'b0, 1'b1);
    exp_r_q.push_back(10);
    for (int e = 1; e <= 25; e++) begin
      tick();
      if (e == 3) reset_btn = 1'b0;
      if (e == 4) reset_btn = 1'b1;
    end
    chk("bounce_reset_stable", {31'd0, reset_stable}, 32'd1);
    end_test();

    // Release glitch: low before edges 11 and 12, high again before edge 13.
    start_test(1'b1, 1'b0);
    exp_s_q.push_back(6);
`ifndef SR_RELEASE_DEBOUNCE_EN
    exp_s_q.push_back(18);
`endif
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 10) set_btn = 1'b0;
      if (e == 12) set_btn = 1'b1;
`ifdef SR_RELEASE_DEBOUNCE_EN
      if (e >= D + 2) chk("glitch_set_stable_held", {31'd0, set_stable}, 32'd1);
`else
      if (e == 13) chk("glitch_set_stable_drop", {31'd0, set_stable}, 32'd0);
      if (e == 18) chk("glitch_set_stable_again", {31'd0, set_stable}, 32'd1);
`endif
    end
    end_test();

    // Reset mid-count: asserted after edge 4, released after edge 6, button held.
    start_test(1'b1, 1'b0);
    exp_s_q.push_back(12);
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 4) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_s_pulse", {31'd0, s_pulse}, 32'd0);
        chk("midrst_r_pulse", {31'd0, r_pulse}, 32'd0);
        chk("midrst_set_stable", {31'd0, set_stable}, 32'd0);
        chk("midrst_reset_stable", {31'd0, reset_stable}, 32'd0);
      end
      if (e == 6) rst_n = 1'b1;
    end
    end_test();

    // Reset while the pulse is high drops it immediately.
    start_test(1'b1, 1'b0);
    for (int e = 1; e <= D + 2; e++) tick();
    chk("inflight_s_pulse_hi", {31'd0, s_pulse}, 32'd1);
    chk("inflight_set_stable_hi", {31'd0, set_stable}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("inflight_s_pulse_drop", {31'd0, s_pulse}, 32'd0);
    chk("inflight_set_stable_drop", {31'd0, set_stable}, 32'd0);
    repeat (2) tick();
    end_test();

    // Long hold: exactly one pulse, stable high throughout.
    start_test(1'b1, 1'b0);
    exp_s_q.push_back(6);
    for (int e = 1; e <= 400; e++) begin
      tick();
      if (e >= D + 2) chk("hold_set_stable", {31'd0, set_stable}, 32'd1);
    end
    set_btn = 1'b0;
    repeat (12) tick();
    chk("hold_set_stable_end", {31'd0, set_stable}, 32'd0);
    end_test();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
